// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the serial configuration-frame receiver.
package serial_rx_pkg;

  // Receiver framing state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } rx_state_t;

  localparam int KEY_W          = 128;
  localparam int ADDR_W         = 8;
  localparam int MODE_W         = 1;
  localparam int FRAME_BITS_DEF = KEY_W + ADDR_W + MODE_W;

  // Running even-parity accumulator: fold one more bit into the XOR of all bits so far.
  function automatic logic par_update(input logic acc, input logic bit_in);
    return acc ^ bit_in;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop pin synchroniser with one extra history flop for edge detection.
// The chain resets to RESET_VAL so an idle pin produces no spurious edge.
module sync_edge_det #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_r;
  logic              prev_r;

  // Shift the pin through the synchroniser and keep the previous synced level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {STAGES{RESET_VAL}};
      prev_r <= RESET_VAL;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], async_in};
      prev_r <= sync_r[STAGES-1];
    end
  end

  assign level = sync_r[STAGES-1];
  assign rise  = sync_r[STAGES-1] & ~prev_r;
  assign fall  = ~sync_r[STAGES-1] & prev_r;

endmodule

// File: rtl/serial_frame_rx.sv
// Serial configuration-frame receiver: synchronises sclk/sdata/cs_n and
// emits one shift strobe per payload bit, MSB first, plus done/error pulses.
// Optional feature: define SERIAL_FRAME_RX_PARITY_EN to expect a trailing
// even-parity bit after the payload; it is checked, never shifted out.
module serial_frame_rx
  import serial_rx_pkg::*;
#(
  parameter int FRAME_BITS  = FRAME_BITS_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk_in,
  input  logic sdata_in,
  input  logic cs_n_in,
  output logic shift_enable,
  output logic serial_in,
  output logic frame_done,
  output logic frame_error,
  output logic busy
);

  localparam int CNT_W = $clog2(FRAME_BITS + 2);

`ifdef SERIAL_FRAME_RX_PARITY_EN
  localparam logic PARITY_ON_C = 1'b1;
`else
  localparam logic PARITY_ON_C = 1'b0;
`endif

  // Synchronised pin views
  logic sclk_rise_s, sclk_lvl_unused_s, sclk_fall_unused_s;
  logic cs_lvl_s, cs_rise_s, cs_fall_s;
  logic sdata_lvl_s, sdata_rise_unused_s, sdata_fall_unused_s;

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk      (clk),
    .rst      (rst),
    .async_in (sclk_in),
    .level    (sclk_lvl_unused_s),
    .rise     (sclk_rise_s),
    .fall     (sclk_fall_unused_s)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs_n (
    .clk      (clk),
    .rst      (rst),
    .async_in (cs_n_in),
    .level    (cs_lvl_s),
    .rise     (cs_rise_s),
    .fall     (cs_fall_s)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdata (
    .clk      (clk),
    .rst      (rst),
    .async_in (sdata_in),
    .level    (sdata_lvl_s),
    .rise     (sdata_rise_unused_s),
    .fall     (sdata_fall_unused_s)
  );

  // State and registered outputs
  rx_state_t        state_r, state_nxt_s;
  logic [CNT_W-1:0] bit_cnt_r, bit_cnt_nxt_s;
  logic             par_r, par_nxt_s;
  logic             shift_enable_r, shift_enable_nxt_s;
  logic             serial_in_r, serial_in_nxt_s;
  logic             frame_done_r, frame_done_nxt_s;
  logic             frame_error_r, frame_error_nxt_s;
  logic             busy_r, busy_nxt_s;
  logic             cnt_full_s;

  assign cnt_full_s = (bit_cnt_r == CNT_W'(FRAME_BITS));

  // Next-state and output decode; a cs_n rise always takes priority over an sclk rise.
  always_comb begin
    state_nxt_s        = state_r;
    bit_cnt_nxt_s      = bit_cnt_r;
    par_nxt_s          = par_r;
    shift_enable_nxt_s = 1'b0;
    serial_in_nxt_s    = serial_in_r;
    frame_done_nxt_s   = 1'b0;
    frame_error_nxt_s  = 1'b0;

    case (state_r)
      IDLE: begin
        if (cs_fall_s) begin
          state_nxt_s   = RECV;
          bit_cnt_nxt_s = {CNT_W{1'b0}};
          par_nxt_s     = 1'b0;
        end else begin
          state_nxt_s = IDLE;
        end
      end

      RECV: begin
        if (cs_rise_s) begin
          // Frame closed by the host: complete only if the payload was full
          // and no parity bit is still owed.
          state_nxt_s = IDLE;
          if (!PARITY_ON_C && cnt_full_s) begin
            frame_done_nxt_s = 1'b1;
          end else begin
            frame_error_nxt_s = 1'b1;
          end
        end else if (!PARITY_ON_C && cnt_full_s) begin
          frame_done_nxt_s = 1'b1;
          state_nxt_s      = DONE;
        end else if (sclk_rise_s && !cs_lvl_s) begin
          if (!cnt_full_s) begin
            shift_enable_nxt_s = 1'b1;
            serial_in_nxt_s    = sdata_lvl_s;
            bit_cnt_nxt_s      = bit_cnt_r + CNT_W'(1);
            par_nxt_s          = par_update(par_r, sdata_lvl_s);
          end else begin
            // Trailing parity bit: even parity over payload plus this bit.
            bit_cnt_nxt_s = bit_cnt_r + CNT_W'(1);
            state_nxt_s   = DONE;
            if (par_update(par_r, sdata_lvl_s) == 1'b0) begin
              frame_done_nxt_s = 1'b1;
            end else begin
              frame_error_nxt_s = 1'b1;
            end
          end
        end else begin
          state_nxt_s = RECV;
        end
      end

      DONE: begin
        if (cs_rise_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end

      default: begin
        state_nxt_s = IDLE;
      end
    endcase

    busy_nxt_s = (state_nxt_s != IDLE);
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      bit_cnt_r      <= {CNT_W{1'b0}};
      par_r          <= 1'b0;
      shift_enable_r <= 1'b0;
      serial_in_r    <= 1'b0;
      frame_done_r   <= 1'b0;
      frame_error_r  <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      bit_cnt_r      <= bit_cnt_nxt_s;
      par_r          <= par_nxt_s;
      shift_enable_r <= shift_enable_nxt_s;
      serial_in_r    <= serial_in_nxt_s;
      frame_done_r   <= frame_done_nxt_s;
      frame_error_r  <= frame_error_nxt_s;
      busy_r         <= busy_nxt_s;
    end
  end

  assign shift_enable = shift_enable_r;
  assign serial_in    = serial_in_r;
  assign frame_done   = frame_done_r;
  assign frame_error  = frame_error_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: full, short, over-long, reset-aborted
// and edge-collision frames, plus parity frames when the parity build is used.
module tb_serial_frame_rx;

  localparam int FB = 137;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic sclk_in, sdata_in, cs_n_in;
  logic shift_enable, serial_in, frame_done, frame_error, busy;

  serial_frame_rx dut (
    .clk          (clk),
    .rst          (rst),
    .sclk_in      (sclk_in),
    .sdata_in     (sdata_in),
    .cs_n_in      (cs_n_in),
    .shift_enable (shift_enable),
    .serial_in    (serial_in),
    .frame_done   (frame_done),
    .frame_error  (frame_error),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Posedge counter used for latency measurements
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge
  int   se_total   = 0;
  int   done_total = 0;
  int   err_total  = 0;
  int   done_cyc   = 0;
  logic rx_bits [0:4095];
  int   se_cyc  [0:4095];

  always @(negedge clk) begin
    if (shift_enable) begin
      rx_bits[se_total] <= serial_in;
      se_cyc[se_total]  <= cyc;
      se_total          <= se_total + 1;
    end
    if (frame_done) begin
      done_total <= done_total + 1;
      done_cyc   <= cyc;
    end
    if (frame_error) err_total <= err_total + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  // Pins change 1 time unit after a rising clk edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Payload pattern: 0xA5 repeated, MSB first
  function automatic logic pat(input int i);
    logic [7:0] a5;
    a5 = 8'hA5;
    return a5[7 - (i % 8)];
  endfunction

  // One serial bit: data set up, then sclk high and low for 3 clk each.
  // Returns the cycle at which sclk rose.
  task automatic send_bit(input logic b, input logic cs_with_edge, output int edge_cyc);
    sdata_in = b;
    tick(3);
    sclk_in  = 1'b1;
    edge_cyc = cyc;
    if (cs_with_edge) cs_n_in = 1'b1;
    tick(3);
    sclk_in = 1'b0;
  endtask

  // Send a frame of nedges sclk rises. Edge FB carries the even parity bit
  // (optionally flipped); further edges carry 0. cs_last raises cs_n together
  // with the final sclk rise. first_edge returns the cycle of edge 0.
  task automatic send_frame(input int nedges, input logic flip, input logic cs_last,
                            output int first_edge);
    logic par;
    logic b;
    int   ec;
    par = 1'b0;
    first_edge = 0;
    cs_n_in = 1'b0;
    tick(4);
    for (int i = 0; i < nedges; i++) begin
      if (i < FB) begin
        b   = pat(i);
        par = par ^ b;
      end else if (i == FB) begin
        b = par ^ flip;
      end else begin
        b = 1'b0;
      end
      send_bit(b, cs_last && (i == nedges - 1), ec);
      if (i == 0) first_edge = ec;
    end
    cs_n_in = 1'b1;
    tick(8);
  endtask

  int se0, d0, e0, fe, bad;

  initial begin
    rst = 1'b1; sclk_in = 1'b0; sdata_in = 1'b0; cs_n_in = 1'b1;
    tick(5);
    chk("reset_outputs", {27'd0, shift_enable, serial_in, frame_done, frame_error, busy}, 32'd0);
    rst = 1'b0;
    tick(3);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // 1: full frame
    se0 = se_total; d0 = done_total; e0 = err_total;
    send_frame(FB + PAR_EN, 1'b0, 1'b0, fe);
    chk("t1_strobes", se_total - se0, FB);
    chk("t1_done", done_total - d0, 1);
    chk("t1_error", err_total - e0, 0);
    bad = 0;
    for (int i = 0; i < FB; i++) if (rx_bits[se0 + i] !== pat(i)) bad++;
    chk("t1_bit_order", bad, 0);
    chk("t1_strobe_latency", se_cyc[se0] - fe, 3);
`ifndef SERIAL_FRAME_RX_PARITY_EN
    chk("t1_done_latency", done_cyc - se_cyc[se0 + FB - 1], 1);
`endif
    chk("t1_busy_after", {31'd0, busy}, 32'd0);

    // 2: short frame of 60 bits
    se0 = se_total; d0 = done_total; e0 = err_total;
    send_frame(60, 1'b0, 1'b0, fe);
    chk("t2_strobes", se_total - se0, 60);
    chk("t2_error", err_total - e0, 1);
    chk("t2_done", done_total - d0, 0);
    chk("t2_busy_after", {31'd0, busy}, 32'd0);

    // 3: 140 edges in one frame
    se0 = se_total; d0 = done_total; e0 = err_total;
    send_frame(140, 1'b0, 1'b0, fe);
    chk("t3_strobes", se_total - se0, FB);
    chk("t3_done", done_total - d0, 1);
    chk("t3_error", err_total - e0, 0);

    // 4: reset after 30 bits, then a full frame
    se0 = se_total; d0 = done_total; e0 = err_total;
    cs_n_in = 1'b0;
    tick(4);
    for (int i = 0; i < 30; i++) send_bit(pat(i), 1'b0, fe);
    tick(4);
    chk("t4_busy_mid", {31'd0, busy}, 32'd1);
    chk("t4_strobes_pre", se_total - se0, 30);
    rst = 1'b1;
    tick(1);
    chk("t4_outs_in_reset", {27'd0, shift_enable, serial_in, frame_done, frame_error, busy}, 32'd0);
    cs_n_in = 1'b1;
    tick(4);
    rst = 1'b0;
    tick(6);
    chk("t4_no_done", done_total - d0, 0);
    chk("t4_no_error", err_total - e0, 0);
    se0 = se_total;
    send_frame(FB + PAR_EN, 1'b0, 1'b0, fe);
    chk("t4_strobes_after", se_total - se0, FB);
    chk("t4_done_after", done_total - d0, 1);

    // 5: final edge collides with cs_n rise
    se0 = se_total; d0 = done_total; e0 = err_total;
    send_frame(FB + PAR_EN, 1'b0, 1'b1, fe);
    chk("t5_strobes", se_total - se0, FB - 1 + PAR_EN);
    chk("t5_error", err_total - e0, 1);
    chk("t5_done", done_total - d0, 0);

`ifdef SERIAL_FRAME_RX_PARITY_EN
    // 6: flipped parity bit
    se0 = se_total; d0 = done_total; e0 = err_total;
    send_frame(FB + 1, 1'b1, 1'b0, fe);
    chk("t6_strobes", se_total - se0, FB);
    chk("t6_error", err_total - e0, 1);
    chk("t6_done", done_total - d0, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
